// File: rtl/uart_pkg.sv
// Shared UART types: arbiter state encoding and parity-mode constants.
// Used by the Tx arbiter and the Tx/Rx datapaths.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner select: first set request at or after ptr, wrapping.
// Purely combinational; returns a one-hot grant and its index.
module uart_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    int j;
    logic [IW-1:0] jj;

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ)
                j = j - NREQ;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one Tx serializer with a level start handshake.
// Optional watchdog abort is enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int n         = 8,
    parameter int WD_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*n-1:0] req_data,
    input  logic [NREQ-1:0] req_parity_odd,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            tx_start,
    output logic [n-1:0]    tx_data,
    output logic            tx_parity_odd,
    input  logic            tx_busy,
    output logic            arb_idle,
    output logic            err
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WD_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_t state, state_nx;

    logic          busy_m, busy_s;
    logic [IW-1:0] ptr, win;
    logic          sel_any;
    logic [NREQ-1:0] sel_oh;
    logic [IW-1:0] sel_idx;
    logic          timeout;
    logic          aborted;

    uart_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .any    (sel_any),
        .onehot (sel_oh),
        .idx    (sel_idx)
    );

    // tx_busy comes from the slower Tx clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= tx_busy;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE:  if (sel_any) state_nx = ARB_START;
            ARB_START: if (timeout) state_nx = ARB_DONE;
                       else if (busy_s) state_nx = ARB_BUSY;
            ARB_BUSY:  if (timeout || !busy_s) state_nx = ARB_DONE;
            ARB_DONE:  state_nx = ARB_IDLE;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt           <= '0;
            win           <= '0;
            ptr           <= '0;
            tx_start      <= 1'b0;
            tx_data       <= '0;
            tx_parity_odd <= PARITY_EVEN;
        end else begin
            tx_start <= (state == ARB_START) && (state_nx == ARB_START);
            if (state == ARB_IDLE && sel_any) begin
                gnt           <= sel_oh;
                win           <= sel_idx;
                tx_data       <= req_data[sel_idx*n +: n];
                tx_parity_odd <= req_parity_odd[sel_idx];
            end
            if (state == ARB_DONE) begin
                gnt <= '0;
                ptr <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
            end
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES);

    logic [WW-1:0] wd_cnt;
    logic          wd_run;

    assign wd_run  = (state == ARB_START) || (state == ARB_BUSY);
    assign timeout = wd_run && (wd_cnt == WW'(WD_CYCLES-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            aborted <= 1'b0;
        end else begin
            if (state_nx != state)
                wd_cnt <= '0;
            else if (wd_run)
                wd_cnt <= wd_cnt + 1'b1;
            if (state_nx == ARB_DONE)
                aborted <= timeout;
        end
    end

    assign err = (state == ARB_DONE) && aborted;
`else
    assign timeout = 1'b0;
    assign aborted = 1'b0;
    assign err     = 1'b0;
`endif

    // gnt still holds the winner during DONE
    assign done     = (state == ARB_DONE && !aborted) ? gnt : '0;
    assign arb_idle = (state == ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural Tx busy responder.
// Define UART_ARB_WATCHDOG_EN to also exercise the watchdog abort.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_parity_odd;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_parity_odd;
    logic        tx_busy;
    logic        arb_idle;
    logic        err;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int err_total = 0;
    bit busy_en = 1'b0;
    logic [7:0] log_data[$];
    logic       log_par[$];

    uart_tx_arbiter #(.NREQ(4), .n(8), .WD_CYCLES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .req_parity_odd (req_parity_odd),
        .gnt            (gnt),
        .done           (done),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_parity_odd  (tx_parity_odd),
        .tx_busy        (tx_busy),
        .arb_idle       (arb_idle),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slow Tx stand-in: accepts a start, then stays busy for a frame
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (busy_en && tx_start === 1'b1) begin
                repeat (3) @(posedge clk);
                #1 tx_busy = 1'b1;
                log_data.push_back(tx_data);
                log_par.push_back(tx_parity_odd);
                repeat (20) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done !== 4'b0000)
            done_total <= done_total + 1;
        if (err === 1'b1)
            err_total <= err_total + 1;
    end

    task automatic wait_done(input string tag, input int exp_idx);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === 4'b0000 && cyc < 300);
        chk({tag, "_seen"}, 32'(done !== 4'b0000), 32'd1);
        chk({tag, "_idx"}, 32'(done), 32'(4'b0001 << exp_idx));
    endtask

    initial begin
        logic [7:0] exp_b[5];
        int         exp_i[5];
        int         cyc;

        rst            = 1'b1;
        req            = '0;
        req_data       = '0;
        req_parity_odd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_par", 32'(tx_parity_odd), 32'd0);
        chk("rst_idle", 32'(arb_idle), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // reset while START is holding tx_start
        req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("mid_start", 32'(tx_start), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_start", 32'(tx_start), 32'd0);
        chk("abort_idle", 32'(arb_idle), 32'd1);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_nodone", 32'(done_total), 32'd0);

        // single request
        busy_en  = 1'b1;
        req_data = 32'h0055_0000;
        req      = 4'b0100;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_data", 32'(tx_data), 32'h55);
        chk("single_start0", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("single_start1", 32'(tx_start), 32'd1);
        wait_done("single", 2);
        req = '0;
        chk("single_log", 32'(log_data[$]), 32'h55);
        chk("single_logpar", 32'(log_par[$]), 32'd0);
        @(negedge clk);
        chk("single_gntclr", 32'(gnt), 32'd0);
        chk("single_idle", 32'(arb_idle), 32'd1);
        chk("single_cnt", 32'(done_total), 32'd1);

        // all requesting from pointer 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        log_data.delete();
        log_par.delete();
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_i = '{0, 1, 2, 3, 0};
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("rr%0d", k), exp_i[k]);
            if (k == 4)
                req = '0;
            chk($sformatf("rr%0d_data", k), 32'(log_data[k]), 32'(exp_b[k]));
        end
        chk("rr_frames", 32'(log_data.size()), 32'd5);
        @(negedge clk);
        chk("rr_cnt", 32'(done_total), 32'd6);

        // request dropped right after grant
        repeat (2) @(negedge clk);
        req_data = 32'h0000_7700;
        req      = 4'b0010;
        @(negedge clk);
        chk("drop_gnt", 32'(gnt), 32'h2);
        req      = '0;
        req_data = '0;
        wait_done("drop", 1);
        chk("drop_log", 32'(log_data[$]), 32'h77);

        // odd parity
        repeat (2) @(negedge clk);
        req_data       = 32'hA500_0000;
        req_parity_odd = 4'b1000;
        req            = 4'b1000;
        @(negedge clk);
        chk("odd_gnt", 32'(gnt), 32'h8);
        chk("odd_par", 32'(tx_parity_odd), 32'd1);
        chk("odd_data", 32'(tx_data), 32'hA5);
        wait_done("odd", 3);
        req            = '0;
        req_parity_odd = '0;
        chk("odd_log", 32'(log_data[$]), 32'hA5);
        chk("odd_logpar", 32'(log_par[$]), 32'd1);
        repeat (2) @(negedge clk);
        chk("odd_cnt", 32'(done_total), 32'd8);

`ifdef UART_ARB_WATCHDOG_EN
        // Tx never answers
        busy_en  = 1'b0;
        req_data = 32'h0000_00C3;
        req      = 4'b0001;
        @(negedge clk);
        chk("wd_gnt", 32'(gnt), 32'h1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (err !== 1'b1 && cyc < 200);
        chk("wd_cycles", 32'(cyc), 32'd64);
        chk("wd_nodone", 32'(done), 32'd0);
        req = '0;
        @(negedge clk);
        chk("wd_idle", 32'(arb_idle), 32'd1);
        chk("wd_gntclr", 32'(gnt), 32'd0);
        chk("wd_err1", 32'(err), 32'd0);
        chk("wd_cnt", 32'(done_total), 32'd8);
        chk("wd_errcnt", 32'(err_total), 32'd1);
`else
        cyc = 0;
        chk("no_err", 32'(err_total + cyc), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
